vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the video controller. Produces pixel_cnt, line_cnt,
//  h_sync, v_sync and video_on for the downstream pixel generator, which uses:
//  - the counters to decide box hits
//  - v_sync edges to step box positions
//  - video_on to blank RGB
//  Also emits a one-cycle frame_start strobe. Default timing is 640x480@60 (800x525 total).
// PARAMETERS
//  CTR_W     12  width of pixel_cnt/line_cnt; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE 640  visible pixels per line
//  H_FP      16  horizontal front porch (pixels)
//  H_SYNC    96  horizontal sync width (pixels)
//  H_BP      48  horizontal back porch (pixels)
//  V_ACTIVE 480  visible lines per frame
//  V_FP      10  vertical front porch (lines)
//  V_SYNC     2  vertical sync width (lines)
//  V_BP      33  vertical back porch (lines)
//  H_POL      0  h_sync active level (0 = active-low)
//  V_POL      0  v_sync active level (0 = active-low)
// PORTS
//  rfr_clk      in   1      pixel-domain clock
//  reset_n      in   1      asynchronous, active-low reset
//  pixel_en     in   1      clock enable; one pixel advances per rfr_clk with pixel_en=1
//  pixel_cnt    out  CTR_W  horizontal position, 0..H_TOTAL-1
//  line_cnt     out  CTR_W  vertical position, 0..V_TOTAL-1
//  h_sync       out  1      horizontal sync, polarity H_POL
//  v_sync       out  1      vertical sync, polarity V_POL
//  video_on     out  1      1 when pixel_cnt<H_ACTIVE and line_cnt<V_ACTIVE
//  frame_start  out  1      1-cycle strobe when counters load (0,0)
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Line layout: active region [0, H_ACTIVE), then FP, SYNC, BP. Frames use the same layout.
//  - Reset state (asynchronous): pixel_cnt=H_TOTAL-1, line_cnt=V_TOTAL-1, h_sync=~H_POL,
//    v_sync=~V_POL, video_on=0, frame_start=0.
//  - Effect: the first enabled edge after reset loads (0,0) with video_on=1 and frame_start=1.
//  - On each rfr_clk edge with pixel_en=1:
//    - If pixel_cnt==H_TOTAL-1, pixel_cnt becomes 0; otherwise it increments by 1.
//    - line_cnt advances only when pixel_cnt wraps. It wraps from V_TOTAL-1 to 0.
//  - With pixel_en=0, all counters, syncs and video_on hold; frame_start is forced to 0.
//  - All outputs are registered and mutually aligned: in any cycle, h_sync, v_sync and
//    video_on describe the pixel_cnt/line_cnt presented in that same cycle.
//    Implement by decoding the next-count values.
//  - h_sync is active when H_ACTIVE+H_FP <= pixel_cnt < H_ACTIVE+H_FP+H_SYNC.
//  - v_sync is active when V_ACTIVE+V_FP <= line_cnt < V_ACTIVE+V_FP+V_SYNC.
//    v_sync therefore changes only together with a pixel_cnt wrap to 0.
//  - frame_start is high for exactly one rfr_clk cycle: the cycle after the enabled edge
//    that loaded (0,0). It is never high for two consecutive cycles.
//  - Reset mid-frame: outputs return to their reset values immediately (no clock needed).
//    Counting restarts cleanly on release; no partial sync pulse is extended.
//  - Arithmetic is unsigned at CTR_W bits. There is no overflow path: the wrap compare
//    precedes the increment.
//  - Elaboration-time check: $error if H_TOTAL or V_TOTAL exceeds 2**CTR_W, or if any
//    timing parameter is 0.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - default 640x480 timing constants (H_*/V_*)
//    - H_TOTAL/V_TOTAL localparam functions
//    - a typedef for CTR_W-wide counter values
//    It is shared with pixel_gen (MAX_PIXEL/MAX_LINE derive from it).
//  - Sub-module wrap_counter (params W, MAX; ports clk, rst_n, en, cnt, wrap) is
//    instantiated twice:
//    - horizontal counter: en = pixel_en
//    - vertical counter:   en = pixel_en & h_wrap
//  - Sync, blanking and frame_start decode stays in this module.
// TESTING
//  1. Release reset with pixel_en=1 -> next cycle: pixel_cnt=0, line_cnt=0, video_on=1,
//     frame_start=1, h_sync=1, v_sync=1. The following cycle has frame_start=0.
//  2. Free-run line 0 -> video_on falls at pixel 640; h_sync falls at 656 and rises at
//     752; pixel 799 is followed by (0, line 1).
//  3. Free-run to line 490 -> v_sync low for lines 490-491 (exactly 1600 cycles).
//     v_sync edges coincide with pixel_cnt=0. video_on=0 for all of lines 480-524.
//  4. Frame wrap at (799,524) -> (0,0) and frame_start=1. Measured frame period is exactly
//     420000 enabled cycles.
//  5. pixel_en toggled 1,0,1,0... -> counters advance only on enabled edges; frame period
//     is 840000 rfr_clk. frame_start stays 1 cycle wide; outputs hold while pixel_en=0.
//  6. Assert reset_n=0 mid-cycle at (700,100) -> outputs take reset values with no clock
//     edge. Release -> test 1 sequence repeats.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the sync generator and pixel generator.
package vga_timing_pkg;

    localparam int CTR_W_DEF    = 12;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef logic [CTR_W_DEF-1:0] ctr_t;

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0; resets to MAX so the first enabled edge lands on 0.
module wrap_counter #(
    parameter int         W   = 12,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= MAX;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, blanking and frame strobe,
// all decoded from next-count values so they line up with the counters they describe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CTR_W    = CTR_W_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic             rfr_clk,
    input  logic             reset_n,
    input  logic             pixel_en,
    output logic [CTR_W-1:0] pixel_cnt,
    output logic [CTR_W-1:0] line_cnt,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic             frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2**CTR_W || V_TOTAL > 2**CTR_W) begin : g_bad_width
        $error("vga_sync_gen: CTR_W=%0d too narrow for %0dx%0d totals", CTR_W, H_TOTAL, V_TOTAL);
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_sync_gen: timing parameters must all be non-zero");
    end

    localparam logic [CTR_W-1:0] H_LAST      = CTR_W'(H_TOTAL - 1);
    localparam logic [CTR_W-1:0] V_LAST      = CTR_W'(V_TOTAL - 1);
    localparam logic [CTR_W-1:0] H_ACT_END   = CTR_W'(H_ACTIVE);
    localparam logic [CTR_W-1:0] V_ACT_END   = CTR_W'(V_ACTIVE);
    localparam logic [CTR_W-1:0] H_SYNC_ON   = CTR_W'(H_ACTIVE + H_FP);
    localparam logic [CTR_W-1:0] H_SYNC_OFF  = CTR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CTR_W-1:0] V_SYNC_ON   = CTR_W'(V_ACTIVE + V_FP);
    localparam logic [CTR_W-1:0] V_SYNC_OFF  = CTR_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             h_wrap;
    logic             v_wrap;
    logic [CTR_W-1:0] px_next;
    logic [CTR_W-1:0] ln_next;
    logic             h_act_next;
    logic             v_act_next;
    logic             vid_next;

    wrap_counter #(.W(CTR_W), .MAX(H_LAST)) u_h_cnt (
        .clk   (rfr_clk),
        .rst_n (reset_n),
        .en    (pixel_en),
        .cnt   (pixel_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.W(CTR_W), .MAX(V_LAST)) u_v_cnt (
        .clk   (rfr_clk),
        .rst_n (reset_n),
        .en    (pixel_en & h_wrap),
        .cnt   (line_cnt),
        .wrap  (v_wrap)
    );

    // Mirror the counters' next values so the registered decode matches the count it accompanies.
    always_comb begin
        px_next = h_wrap ? '0 : pixel_cnt + 1'b1;
        ln_next = line_cnt;
        if (h_wrap) begin
            ln_next = v_wrap ? '0 : line_cnt + 1'b1;
        end
        h_act_next = (px_next >= H_SYNC_ON) && (px_next < H_SYNC_OFF);
        v_act_next = (ln_next >= V_SYNC_ON) && (ln_next < V_SYNC_OFF);
        vid_next   = (px_next < H_ACT_END) && (ln_next < V_ACT_END);
    end

    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pixel_en) begin
            h_sync      <= h_act_next ? H_POL : ~H_POL;
            v_sync      <= v_act_next ? V_POL : ~V_POL;
            video_on    <= vid_next;
            frame_start <= h_wrap & v_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced raster so whole frames run quickly.
module tb_vga_sync_gen;

    localparam int CW = 8;
    localparam int HA = 20, HF = 4, HS = 6, HB = 5;
    localparam int VA = 12, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          rfr_clk;
    logic          reset_n;
    logic          pixel_en;
    logic [CW-1:0] pixel_cnt;
    logic [CW-1:0] line_cnt;
    logic          h_sync;
    logic          v_sync;
    logic          video_on;
    logic          frame_start;

    vga_sync_gen #(
        .CTR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .rfr_clk(rfr_clk), .reset_n(reset_n), .pixel_en(pixel_en),
        .pixel_cnt(pixel_cnt), .line_cnt(line_cnt), .h_sync(h_sync),
        .v_sync(v_sync), .video_on(video_on), .frame_start(frame_start)
    );

    initial begin
        rfr_clk = 1'b0;
        forever #5 rfr_clk = ~rfr_clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: linear position within the frame, counted in enabled edges.
    int   pos;
    logic fs_m;

    typedef struct {
        logic en;
        int   px;
        int   ln;
        logic hs;
        logic vs;
        logic vo;
        logic fs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int in_range(input int v, input int lo, input int hi);
        return (v >= lo && v < hi) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        int px, ln;
        px = pos % HT;
        ln = pos / HT;
        chk({tag, ".pixel_cnt"}, int'(pixel_cnt), px);
        chk({tag, ".line_cnt"},  int'(line_cnt),  ln);
        chk({tag, ".h_sync"},    int'(h_sync),    1 - in_range(px, HA + HF, HA + HF + HS));
        chk({tag, ".v_sync"},    int'(v_sync),    1 - in_range(ln, VA + VF, VA + VF + VS));
        chk({tag, ".video_on"},  int'(video_on),  (px < HA && ln < VA) ? 1 : 0);
        chk({tag, ".frame_start"}, int'(frame_start), int'(fs_m));
    endtask

    task automatic step(input logic en);
        pixel_en = en;
        @(posedge rfr_clk);
        if (reset_n && en) begin
            pos  = (pos + 1) % FT;
            fs_m = (pos == 0);
        end else begin
            fs_m = 1'b0;
        end
        @(negedge rfr_clk);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        pixel_en = 1'b0;
        pos      = FT - 1;
        fs_m     = 1'b0;
        @(negedge rfr_clk);
        @(negedge rfr_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int vo_fall, hs_fall, hs_rise, p_prev, l_prev, vs_cnt, bad_edge, vid_blank, flen, budget;
        logic vo_prev, hs_prev, vs_prev, fs_prev, seen;

        vecs[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset_n  = 1'b0;
        pixel_en = 1'b0;
        apply_reset();

        // Reset state then startup vectors
        chk("rst.pixel_cnt", int'(pixel_cnt), HT - 1);
        chk("rst.line_cnt",  int'(line_cnt),  VT - 1);
        chk("rst.h_sync",    int'(h_sync),    1);
        chk("rst.v_sync",    int'(v_sync),    1);
        chk("rst.video_on",  int'(video_on),  0);
        chk("rst.frame_start", int'(frame_start), 0);
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].en);
            chk($sformatf("vec%0d.pixel_cnt", i), int'(pixel_cnt), vecs[i].px);
            chk($sformatf("vec%0d.line_cnt", i),  int'(line_cnt),  vecs[i].ln);
            chk($sformatf("vec%0d.h_sync", i),    int'(h_sync),    int'(vecs[i].hs));
            chk($sformatf("vec%0d.v_sync", i),    int'(v_sync),    int'(vecs[i].vs));
            chk($sformatf("vec%0d.video_on", i),  int'(video_on),  int'(vecs[i].vo));
            chk($sformatf("vec%0d.frame_start", i), int'(frame_start), int'(vecs[i].fs));
        end

        // Line 0 edges
        apply_reset();
        step(1'b1);
        vo_fall = -1; hs_fall = -1; hs_rise = -1;
        vo_prev = video_on; hs_prev = h_sync;
        for (int i = 1; i < HT; i++) begin
            step(1'b1);
            if (vo_prev && !video_on) vo_fall = int'(pixel_cnt);
            if (hs_prev && !h_sync)   hs_fall = int'(pixel_cnt);
            if (!hs_prev && h_sync)   hs_rise = int'(pixel_cnt);
            vo_prev = video_on; hs_prev = h_sync;
        end
        chk("line0.last_pixel", int'(pixel_cnt), HT - 1);
        step(1'b1);
        chk("line0.vo_fall", vo_fall, HA);
        chk("line0.hs_fall", hs_fall, HA + HF);
        chk("line0.hs_rise", hs_rise, HA + HF + HS);
        chk("line0.wrap_px", int'(pixel_cnt), 0);
        chk("line0.wrap_ln", int'(line_cnt), 1);

        // One full frame: v_sync width, edge alignment, vertical blanking, frame period
        apply_reset();
        step(1'b1);
        vs_cnt = 0; bad_edge = 0; vid_blank = 0; flen = 0; seen = 1'b0;
        vs_prev = v_sync;
        budget = 2 * FT;
        while (!seen && budget > 0) begin
            step(1'b1);
            budget--;
            flen++;
            check_model("frame");
            if (!v_sync) vs_cnt++;
            if (v_sync != vs_prev && pixel_cnt != '0) bad_edge++;
            if (int'(line_cnt) >= VA && video_on) vid_blank++;
            vs_prev = v_sync;
            if (frame_start) seen = 1'b1;
        end
        chk("frame.timeout", int'(seen), 1);
        chk("frame.vsync_cycles", vs_cnt, VS * HT);
        chk("frame.vsync_edge_px0", bad_edge, 0);
        chk("frame.vblank_video_on", vid_blank, 0);
        chk("frame.period", flen, FT);
        chk("frame.wrap_px", int'(pixel_cnt), 0);
        chk("frame.wrap_ln", int'(line_cnt), 0);

        // Alternating enable: half-rate frame, one-cycle strobe, hold while disabled
        apply_reset();
        flen = 0; seen = 1'b0; fs_prev = 1'b0; bad_edge = 0;
        budget = 3 * FT;
        begin
            int first_at, second_at, cyc;
            first_at = -1; second_at = -1; cyc = 0;
            while (second_at < 0 && budget > 0) begin
                p_prev = int'(pixel_cnt); l_prev = int'(line_cnt);
                step(cyc[0] == 1'b0);
                cyc++;
                budget--;
                check_model("toggle");
                if (cyc[0] == 1'b0) begin
                    chk("toggle.hold_px", int'(pixel_cnt), p_prev);
                    chk("toggle.hold_ln", int'(line_cnt), l_prev);
                end
                if (fs_prev && frame_start) bad_edge++;
                fs_prev = frame_start;
                if (frame_start) begin
                    if (first_at < 0) first_at = cyc;
                    else second_at = cyc;
                end
            end
            chk("toggle.timeout", (second_at >= 0) ? 1 : 0, 1);
            chk("toggle.period", second_at - first_at, 2 * FT);
            chk("toggle.fs_double", bad_edge, 0);
        end

        // Asynchronous reset mid-frame, then restart
        budget = FT;
        while (!(int'(pixel_cnt) == HA + HF + 2 && int'(line_cnt) == 7) && budget > 0) begin
            step(1'b1);
            budget--;
        end
        chk("midrst.reach", budget > 0 ? 1 : 0, 1);
        chk("midrst.h_sync_pre", int'(h_sync), 0);
        #2;
        reset_n = 1'b0;
        pos = FT - 1; fs_m = 1'b0;
        #1;
        check_model("midrst");
        @(negedge rfr_clk);
        reset_n = 1'b1;
        step(1'b1);
        chk("midrst.restart_px", int'(pixel_cnt), 0);
        chk("midrst.restart_ln", int'(line_cnt), 0);
        chk("midrst.restart_fs", int'(frame_start), 1);
        chk("midrst.restart_vo", int'(video_on), 1);
        step(1'b1);
        chk("midrst.fs_drop", int'(frame_start), 0);

        // Randomised enable with sporadic asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                #2;
                reset_n = 1'b0;
                pos = FT - 1; fs_m = 1'b0;
                #1;
                check_model("rand_rst");
                @(negedge rfr_clk);
                reset_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
